pll_lock_supervisor: RTL and testbench

//  Consumes the asynchronous PLL LOCK output and turns it into a clean, held system reset.

---
 rtl/pll_sup_pkg.sv | 26 ++
 rtl/sync_ff.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and a
// constant-friendly ceiling-log2 helper used to size the cycle counter.
package pll_sup_pkg;

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABLE    = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = WAIT_LOCK,
    S_STABLE    = STABLE,
    S_HOLD      = HOLD,
    S_RUN       = RUN,
    S_FAULT     = FAULT
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for a single asynchronous level; all stages
// clear to 0 on synchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns the asynchronous PLL LOCK into a held, glitch-free system reset and
// counts run-time lock losses. Define PLL_SUP_STICKY_FAULT_EN to latch losses in FAULT.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_async,
  input  logic             clr_count,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             loss_pulse,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);

  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CNT_W-1:0] LOSS_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

  logic            lk_s;
  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic            sys_rst_n_r;
  logic            ready_r;
  logic            loss_pulse_r;
  logic [CNT_W-1:0] loss_count_r;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked_async),
    .q     (lk_s)
  );

  // Supervisor FSM with window counter, registered outputs and loss counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_WAIT_LOCK;
      cnt_r        <= '0;
      sys_rst_n_r  <= 1'b0;
      ready_r      <= 1'b0;
      loss_pulse_r <= 1'b0;
      loss_count_r <= '0;
    end else begin
      loss_pulse_r <= 1'b0;
      // A loss in the same cycle as a clear overrides this to exactly one.
      if (clr_count) begin
        loss_count_r <= '0;
      end
      case (state_r)
        S_WAIT_LOCK: begin
          cnt_r <= '0;
          if (lk_s) begin
            state_r <= S_STABLE;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_r <= S_HOLD;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (!lk_s) begin
            state_r <= S_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == HOLD_LAST) begin
            state_r     <= S_RUN;
            cnt_r       <= '0;
            sys_rst_n_r <= 1'b1;
            ready_r     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
`ifdef PLL_SUP_STICKY_FAULT_EN
            state_r <= S_FAULT;
`else
            state_r <= S_WAIT_LOCK;
`endif
            sys_rst_n_r  <= 1'b0;
            ready_r      <= 1'b0;
            loss_pulse_r <= 1'b1;
            if (clr_count) begin
              loss_count_r <= LOSS_ONE;
            end else if (loss_count_r != LOSS_MAX) begin
              loss_count_r <= loss_count_r + LOSS_ONE;
            end
          end
        end
`ifdef PLL_SUP_STICKY_FAULT_EN
        S_FAULT: begin
          cnt_r <= '0;
          if (clr_count) begin
            state_r <= S_WAIT_LOCK;
          end
        end
`endif
        default: begin
          state_r     <= S_WAIT_LOCK;
          cnt_r       <= '0;
          sys_rst_n_r <= 1'b0;
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign sys_rst_n  = sys_rst_n_r;
  assign ready      = ready_r;
  assign loss_pulse = loss_pulse_r;
  assign loss_count = loss_count_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected latencies and counts are
// queued when stimulus is applied and compared when the DUT responds.
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  localparam int HOLD_CYCLES   = 4;
  localparam int CNT_W         = 2;
  localparam int RISE_LAT      = SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES;
  localparam int FALL_LAT      = SYNC_STAGES + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             locked_async;
  logic             clr_count;
  logic             sys_rst_n;
  logic             ready;
  logic             loss_pulse;
  logic [CNT_W-1:0] loss_count;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked_async (locked_async),
    .clr_count    (clr_count),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .loss_pulse   (loss_pulse),
    .loss_count   (loss_count)
  );

  always #20 clk = ~clk;

  task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      e.tag = "sb_underflow";
      e.val = -1;
    end else begin
      e = sb_q.pop_front();
    end
    chk_value(e.tag, obs, e.val);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise lock and count edges until sys_rst_n rises.
  task automatic measure_rise(input string tag);
    int n;
    bit pulse_seen;
    bit rdy_mis;
    sb_push({tag, "_lat"}, RISE_LAT);
    locked_async = 1'b1;
    n = 0;
    pulse_seen = 1'b0;
    rdy_mis = 1'b0;
    while (n < 40) begin
      tick(1);
      n++;
      if (loss_pulse !== 1'b0) pulse_seen = 1'b1;
      if (ready !== sys_rst_n) rdy_mis = 1'b1;
      if (sys_rst_n === 1'b1) break;
    end
    sb_check(n);
    chk_value({tag, "_ready"}, ready, 1);
    chk_value({tag, "_ready_tracks"}, rdy_mis, 0);
    chk_value({tag, "_no_pulse"}, pulse_seen, 0);
  endtask

  // Drop lock in RUN, optionally pulsing clr_count on the loss edge.
  task automatic lose(input string tag, input int exp_cnt, input bit with_clr);
    int n;
    int extra;
    logic first_pulse;
    sb_push({tag, "_lat"}, FALL_LAT);
    sb_push({tag, "_cnt"}, exp_cnt);
    locked_async = 1'b0;
    n = 0;
    first_pulse = 1'b0;
    while (n < 40) begin
      if (with_clr && n == FALL_LAT - 1) clr_count = 1'b1;
      tick(1);
      clr_count = 1'b0;
      n++;
      if (sys_rst_n === 1'b0) begin
        first_pulse = loss_pulse;
        break;
      end
    end
    sb_check(n);
    chk_value({tag, "_pulse"}, first_pulse, 1);
    chk_value({tag, "_ready_low"}, ready, 0);
    extra = 0;
    repeat (6) begin
      tick(1);
      if (loss_pulse !== 1'b0) extra++;
    end
    chk_value({tag, "_single_pulse"}, extra, 0);
    sb_check(loss_count);
  endtask

  initial begin
    bit seen;

    // Case 1: reset values, then quiet while lock stays low.
    rst_n = 1'b0;
    locked_async = 1'b0;
    clr_count = 1'b0;
    tick(3);
    sb_push("rst_sys_rst_n", 0);
    sb_push("rst_ready", 0);
    sb_push("rst_loss_pulse", 0);
    sb_push("rst_loss_count", 0);
    sb_check(sys_rst_n);
    sb_check(ready);
    sb_check(loss_pulse);
    sb_check(loss_count);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      tick(1);
      if (sys_rst_n !== 1'b0 || ready !== 1'b0 || loss_pulse !== 1'b0 || loss_count !== 2'd0) seen = 1'b1;
    end
    chk_value("idle_50", seen, 0);

    // Case 3 then 2: short lock glitch in STABLE, then a full clean rise.
    locked_async = 1'b1;
    tick(5);
    locked_async = 1'b0;
    tick(1);
    measure_rise("rise_after_glitch");
    sb_push("glitch_not_counted", 0);
    sb_check(loss_count);

`ifndef PLL_SUP_STICKY_FAULT_EN
    // Case 4: repeated losses saturate the 2-bit counter at 3.
    for (int k = 1; k <= 5; k++) begin
      lose($sformatf("loss%0d", k), (k < 3) ? k : 3, 1'b0);
      measure_rise($sformatf("relock%0d", k));
    end
`else
    lose("loss_sticky", 1, 1'b0);
    locked_async = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick(1);
      if (sys_rst_n !== 1'b0 || ready !== 1'b0) seen = 1'b1;
    end
    chk_value("fault_holds_reset", seen, 0);
    locked_async = 1'b0;
    tick(3);
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
    sb_push("fault_clr_count", 0);
    sb_check(loss_count);
    measure_rise("fault_relock");
`endif

    // Case 5: clear coinciding with a loss leaves one; a lone clear empties.
    lose("loss_with_clr", 1, 1'b1);
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
    sb_push("clr_lone", 0);
    sb_check(loss_count);

    // Case 6: reset during HOLD discards state and counts.
`ifndef PLL_SUP_STICKY_FAULT_EN
    measure_rise("pre_rst_rise");
    lose("pre_rst_loss", 1, 1'b0);
`endif
    locked_async = 1'b1;
    tick(RISE_LAT - 2);
    chk_value("hold_still_reset", sys_rst_n, 0);
    rst_n = 1'b0;
    tick(1);
    sb_push("hold_rst_sys_rst_n", 0);
    sb_push("hold_rst_ready", 0);
    sb_push("hold_rst_loss_pulse", 0);
    sb_push("hold_rst_loss_count", 0);
    sb_check(sys_rst_n);
    sb_check(ready);
    sb_check(loss_pulse);
    sb_check(loss_count);
    rst_n = 1'b1;
    measure_rise("post_rst_rise");

    chk_value("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
